// File: rtl/bcd_down_counter_pkg.sv
// bcd_down_counter_pkg: shared BCD digit type, digit limit and validity helper
package bcd_down_counter_pkg;
  localparam logic [3:0] BCD_MAX = 4'd9;
  typedef logic [3:0] bcd_digit_t;
  function automatic logic is_bcd(input bcd_digit_t d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_digit_down.sv
// bcd_digit_down: combinational next-value logic for one BCD digit of the down counter
module bcd_digit_down
  import bcd_down_counter_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       borrow_in,
  input  bcd_digit_t load_digit,
  input  logic       load,
  output bcd_digit_t next_digit,
  output logic       borrow_out
);
  // Out-of-range digits recover to 0 without borrowing from the next digit
  assign next_digit = load ? load_digit :
                      !borrow_in ? digit :
                      !is_bcd(digit) ? 4'd0 :
                      digit == 4'd0 ? BCD_MAX : digit - 4'd1;
  assign borrow_out = !load && borrow_in && digit == 4'd0;
endmodule

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: cascaded BCD down counter with validated parallel load and optional wrap
module bcd_down_counter
  import bcd_down_counter_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  wrap_en,
  output logic [4*DIGITS-1:0]   count,
  output logic                  zero,
  output logic                  borrow,
  output logic                  load_err
);
  logic [4*DIGITS-1:0] next_count;
  logic                load_ok;
  logic                valid;
  logic                chain [0:DIGITS];
  always_comb begin
    valid = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (!is_bcd(load_val[4*i+:4])) valid = 1'b0;
  end
  assign load_ok  = load && valid;
  assign chain[0] = en && !load;
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_down u_digit (
        .digit      (count[4*g+:4]),
        .borrow_in  (chain[g]),
        .load_digit (load_val[4*g+:4]),
        .load       (load_ok),
        .next_digit (next_count[4*g+:4]),
        .borrow_out (chain[g+1])
      );
    end
  endgenerate
  assign zero = count == '0;
  // A borrow out of the top digit means an enabled decrement at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      borrow   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= (chain[DIGITS] && !wrap_en) ? count : next_count;
      borrow   <= chain[DIGITS];
      load_err <= load && !valid;
    end
  end
endmodule

// File: tb/tb_bcd_down_counter.sv
// tb_bcd_down_counter: directed vector table plus randomized run against a decimal reference model
module tb_bcd_down_counter;
  localparam int D = 2;
  localparam int W = 4 * D;
  localparam int MAXV = 99;
  logic clk = 1'b0;
  logic reset, en, load, wrap_en;
  logic [W-1:0] load_val, count;
  logic zero, borrow, load_err;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic rst, ld, en, wr;
    logic [W-1:0] lv, ec;
    logic ez, eb, ee;
  } vec_t;
  vec_t vq[$];
  bcd_down_counter #(.DIGITS(D)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .wrap_en(wrap_en), .count(count), .zero(zero), .borrow(borrow), .load_err(load_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic void add(input logic rst, ld, e, wr, input logic [W-1:0] lv, ec,
                              input logic ez, eb, ee);
    vec_t v;
    v.rst = rst; v.ld = ld; v.en = e; v.wr = wr; v.lv = lv; v.ec = ec;
    v.ez = ez; v.eb = eb; v.ee = ee;
    vq.push_back(v);
  endfunction
  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r;
    for (int i = 0; i < D; i++) begin
      r[4*i+:4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction
  task automatic step(input logic r, l, e, w, input logic [W-1:0] v);
    reset = r; load = l; en = e; wrap_en = w; load_val = v;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int model, err_exp, bor_exp;
    logic ok;
    reset = 1'b1; load = 1'b0; en = 1'b0; wrap_en = 1'b0; load_val = '0;
    // rst ld en wr lv ec z b e
    add(1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 1, 0, 0, 8'h10, 8'h10, 0, 0, 0);
    add(0, 0, 1, 0, 8'h00, 8'h09, 0, 0, 0);
    add(0, 1, 0, 0, 8'h02, 8'h02, 0, 0, 0);
    add(0, 0, 1, 0, 8'h00, 8'h01, 0, 0, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 1, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 1, 1, 0);
    add(0, 0, 1, 1, 8'h00, 8'h99, 0, 1, 0);
    add(0, 0, 1, 1, 8'h00, 8'h98, 0, 0, 0);
    add(0, 1, 0, 0, 8'h45, 8'h45, 0, 0, 0);
    add(0, 1, 1, 0, 8'h3A, 8'h45, 0, 0, 1);
    add(0, 0, 0, 0, 8'h00, 8'h45, 0, 0, 0);
    add(0, 1, 1, 0, 8'h57, 8'h57, 0, 0, 0);
    add(0, 0, 0, 1, 8'h00, 8'h57, 0, 0, 0);
    add(0, 1, 0, 0, 8'h31, 8'h31, 0, 0, 0);
    add(0, 0, 1, 0, 8'h00, 8'h30, 0, 0, 0);
    add(1, 1, 1, 1, 8'h22, 8'h00, 1, 0, 0);
    add(0, 0, 1, 1, 8'h00, 8'h99, 0, 1, 0);
    add(0, 1, 0, 0, 8'h9F, 8'h99, 0, 0, 1);
    add(0, 1, 1, 0, 8'hF0, 8'h99, 0, 0, 1);
    add(0, 0, 1, 0, 8'h00, 8'h98, 0, 0, 0);
    add(0, 1, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0);
    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].ld, vq[i].en, vq[i].wr, vq[i].lv);
      check($sformatf("vec%0d count", i), count, vq[i].ec);
      check($sformatf("vec%0d zero", i), W'(zero), W'(vq[i].ez));
      check($sformatf("vec%0d borrow", i), W'(borrow), W'(vq[i].eb));
      check($sformatf("vec%0d load_err", i), W'(load_err), W'(vq[i].ee));
    end
    step(1, 0, 0, 0, '0);
    model = 0;
    for (int c = 0; c < 3000; c++) begin
      logic r, l, e, w;
      logic [W-1:0] v;
      r = $urandom_range(0, 49) == 0;
      l = $urandom_range(0, 5) == 0;
      e = $urandom_range(0, 2) != 0;
      w = $urandom_range(0, 1) == 1;
      for (int i = 0; i < D; i++) v[4*i+:4] = 4'($urandom_range(0, 11));
      ok = 1'b1;
      for (int i = 0; i < D; i++) if (v[4*i+:4] > 9) ok = 1'b0;
      err_exp = 0; bor_exp = 0;
      if (r) model = 0;
      else if (l) begin
        if (ok) begin
          model = 0;
          for (int i = D - 1; i >= 0; i--) model = model * 10 + int'(v[4*i+:4]);
        end else err_exp = 1;
      end else if (e) begin
        if (model == 0) begin
          bor_exp = 1;
          model = w ? MAXV : 0;
        end else model = model - 1;
      end
      step(r, l, e, w, v);
      check("rand count", count, to_bcd(model));
      check("rand zero", W'(zero), W'(model == 0));
      check("rand borrow", W'(borrow), W'(bor_exp));
      check("rand load_err", W'(load_err), W'(err_exp));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
